lv_lbist_seq: RTL and testbench

LV_LBIST_SEQ -- requirements
Module: lv_lbist_seq

---
 rtl/lv_lbist_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_lv_lbist_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv_lbist_seq.sv
// lv_lbist_seq -- low-voltage logic BIST sequencer.
//
// Walks the BIST channels one at a time. Each channel receives REQ_NUM
// request/ack handshakes separated by a one-cycle gap. A channel passes when
// at least OK_TH of its acks arrive without an error flag and all of them
// arrive before the per-channel timeout. An external fault pulse seen while
// busy is recorded separately. Dropping i_bist_en aborts a run; evaluated
// results are kept.
//
// Optional feature (macro LV_LBIST_RETRY_EN): a channel that fails is re-run
// once from scratch and only the retry result is kept.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_bist_en      level: high starts/holds a run, low aborts or ends it
//   o_ch_req       registered one-hot (or zero) request per channel
//   i_ch_ack       single-cycle ack per channel
//   i_ch_err       error flag, valid only with the matching ack bit
//   i_fault_pulse  external fault pulse, monitored while busy
//   o_ch_rult      per-channel result, 1 = pass
//   o_fault_rult   1 = no fault pulse seen during the run
//   o_bist_busy    high while requesting, in gap or evaluating
//   o_lv_bist_done high once every channel has been evaluated
module lv_lbist_seq #(
  parameter int CH_NUM  = 4,
  parameter int REQ_NUM = 4,
  parameter int OK_TH   = 3,
  parameter int CLK_M   = 1,
  parameter int TMO_TH  = 2000 * CLK_M
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bist_en,
  output logic [CH_NUM-1:0] o_ch_req,
  input  logic [CH_NUM-1:0] i_ch_ack,
  input  logic [CH_NUM-1:0] i_ch_err,
  input  logic              i_fault_pulse,
  output logic [CH_NUM-1:0] o_ch_rult,
  output logic              o_fault_rult,
  output logic              o_bist_busy,
  output logic              o_lv_bist_done
);

  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int NW = $clog2(REQ_NUM + 1);
  localparam int TW = $clog2(TMO_TH);

  localparam logic [CW-1:0] CH_LAST  = CW'(CH_NUM - 1);
  localparam logic [NW-1:0] REQ_MAX  = NW'(REQ_NUM);
  localparam logic [NW-1:0] OK_MIN   = NW'(OK_TH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_TH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_idx_q, ch_idx_d;
  logic [NW-1:0]       issued_q, issued_d;
  logic [NW-1:0]       ok_q, ok_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                tmo_hit_q, tmo_hit_d;
  logic [CH_NUM-1:0]   ch_rult_q, ch_rult_d;
  logic                fault_q, fault_d;
  logic [CH_NUM-1:0]   ch_req_q, ch_req_d;
  logic                clr_s;
  logic                busy_s;
  logic                pass_s;
`ifdef LV_LBIST_RETRY_EN
  logic                retry_q, retry_d;
`endif

  assign busy_s = (state_q == S_REQ) || (state_q == S_GAP) || (state_q == S_EVAL);
  assign pass_s = (ok_q >= OK_MIN) && !tmo_hit_q;

  // Next-state, counter and result logic.
  always_comb begin
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    issued_d  = issued_q;
    ok_d      = ok_q;
    tmo_d     = tmo_q;
    tmo_hit_d = tmo_hit_q;
    ch_rult_d = ch_rult_q;
    clr_s     = 1'b0;
    // A fault pulse during a run latches the fault result low until restart.
    fault_d   = (busy_s && i_fault_pulse) ? 1'b0 : fault_q;
`ifdef LV_LBIST_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_bist_en) begin
          state_d   = S_REQ;
          ch_idx_d  = '0;
          ch_rult_d = '1;
          fault_d   = 1'b1;
          clr_s     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!i_bist_en) begin
          state_d = S_IDLE;
          clr_s   = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          // Timeout beats a same-cycle ack; that ack is dropped.
          state_d   = S_EVAL;
          tmo_hit_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (i_ch_ack[ch_idx_q]) begin
            state_d  = S_GAP;
            issued_d = (issued_q != REQ_MAX) ? issued_q + 1'b1 : issued_q;
            ok_d     = (!i_ch_err[ch_idx_q] && (ok_q != REQ_MAX)) ? ok_q + 1'b1 : ok_q;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_GAP: begin
        if (!i_bist_en) begin
          state_d = S_IDLE;
          clr_s   = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_EVAL;
          tmo_hit_d = 1'b1;
        end else begin
          tmo_d   = tmo_q + 1'b1;
          state_d = (issued_q == REQ_MAX) ? S_EVAL : S_REQ;
        end
      end
      S_EVAL: begin
        clr_s = 1'b1;
        if (!i_bist_en) begin
          // Abort wins: this channel keeps its initial 1.
          state_d = S_IDLE;
`ifdef LV_LBIST_RETRY_EN
        end else if (!pass_s && !retry_q) begin
          // First failure: re-run the same channel, result comes from the retry.
          state_d = S_REQ;
          retry_d = 1'b1;
`endif
        end else begin
          ch_rult_d[ch_idx_q] = pass_s;
`ifdef LV_LBIST_RETRY_EN
          retry_d = 1'b0;
`endif
          if (ch_idx_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            ch_idx_d = ch_idx_q + 1'b1;
            state_d  = S_REQ;
          end
        end
      end
      S_DONE: begin
        if (!i_bist_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        clr_s   = 1'b1;
      end
    endcase

    if (clr_s) begin
      issued_d  = '0;
      ok_d      = '0;
      tmo_d     = '0;
      tmo_hit_d = 1'b0;
    end else begin
      tmo_hit_d = tmo_hit_d;
    end

`ifdef LV_LBIST_RETRY_EN
    if (state_d == S_IDLE) begin
      retry_d = 1'b0;
    end else begin
      retry_d = retry_d;
    end
`endif

    // Request is registered so it is high exactly while the FSM sits in REQ.
    ch_req_d = '0;
    if (state_d == S_REQ) begin
      ch_req_d[ch_idx_d] = 1'b1;
    end else begin
      ch_req_d = '0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ch_idx_q  <= '0;
      issued_q  <= '0;
      ok_q      <= '0;
      tmo_q     <= '0;
      tmo_hit_q <= 1'b0;
      ch_rult_q <= '1;
      fault_q   <= 1'b1;
      ch_req_q  <= '0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      issued_q  <= issued_d;
      ok_q      <= ok_d;
      tmo_q     <= tmo_d;
      tmo_hit_q <= tmo_hit_d;
      ch_rult_q <= ch_rult_d;
      fault_q   <= fault_d;
      ch_req_q  <= ch_req_d;
    end
  end

`ifdef LV_LBIST_RETRY_EN
  // Retry-taken flag for the channel under test.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign o_ch_req       = ch_req_q;
  assign o_ch_rult      = ch_rult_q;
  assign o_fault_rult   = fault_q;
  assign o_bist_busy    = busy_s;
  assign o_lv_bist_done = (state_q == S_DONE);

endmodule

// File: tb/tb_lv_lbist_seq.sv
// Self-checking bench for lv_lbist_seq (CH_NUM=4, REQ_NUM=4, OK_TH=3, TMO_TH=64).
// A per-channel response script (ack latency and error flag per request) is
// played by a responder; expected results come from a transaction-level model
// of the pass/timeout rules applied to that script.
module tb_lv_lbist_seq;
  localparam int CH  = 4;
  localparam int RN  = 4;
  localparam int OKT = 3;
  localparam int TMO = 64;
`ifdef LV_LBIST_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bist_en = 1'b0;
  logic [CH-1:0] ch_req;
  logic [CH-1:0] ch_ack = '0;
  logic [CH-1:0] ch_err = '0;
  logic          fault_pulse = 1'b0;
  logic [CH-1:0] ch_rult;
  logic          fault_rult;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  lv_lbist_seq #(
    .CH_NUM(CH), .REQ_NUM(RN), .OK_TH(OKT), .TMO_TH(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(bist_en),
    .o_ch_req(ch_req), .i_ch_ack(ch_ack), .i_ch_err(ch_err),
    .i_fault_pulse(fault_pulse), .o_ch_rult(ch_rult),
    .o_fault_rult(fault_rult), .o_bist_busy(busy), .o_lv_bist_done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int            lat_t [CH][8];
  bit            err_t [CH][8];
  logic [CH-1:0] exp_rult;
  int            exp_busy;
  int            exp_edges [CH];
  int            edges [CH];
  int            m_cnt [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_clean(input int c, input int maxlat, input bit rnd_err);
    for (int i = 0; i < 8; i++) begin
      lat_t[c][i] = $urandom_range(1, maxlat);
      err_t[c][i] = rnd_err ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic set_fixed(input int c, input int lat);
    for (int i = 0; i < 8; i++) begin
      lat_t[c][i] = lat;
      err_t[c][i] = 1'b0;
    end
  endtask

  // Transaction-level model: each request costs its ack latency plus one gap
  // cycle; the 64th requesting/gap cycle of an attempt is a timeout.
  task automatic model_run();
    exp_busy = 0;
    for (int c = 0; c < CH; c++) begin
      int k;
      bit pass;
      k = 0;
      pass = 1'b0;
      for (int a = 0; a < ATTEMPTS; a++) begin
        int t;
        int ok;
        bit tmo;
        t = 0; ok = 0; tmo = 1'b0;
        for (int i = 0; i < RN && !tmo; i++) begin
          int  lat;
          bit  e;
          lat = lat_t[c][k];
          e   = err_t[c][k];
          k++;
          if (t + lat > TMO - 1) begin
            tmo = 1'b1;
          end else begin
            if (!e) ok++;
            t += lat + 1;
            if (t > TMO - 1) tmo = 1'b1;
          end
        end
        if (tmo) t = TMO;
        exp_busy += t + 1;
        pass = !tmo && (ok >= OKT);
        if (pass) break;
      end
      exp_rult[c]  = pass;
      exp_edges[c] = k;
    end
  endtask

  task automatic run_test(input string name, input int abort_ch, input int fault_ch, input int rst_ch);
    logic [CH-1:0] req;
    logic [CH-1:0] prev_req;
    logic [CH-1:0] ack_v;
    logic [CH-1:0] err_v;
    logic [CH-1:0] part_rult;
    int            busy_cnt;
    int            cyc;
    bit            finished;
    bit            fault_seen;
    model_run();
    for (int c = 0; c < CH; c++) begin
      edges[c] = 0;
      m_cnt[c] = 0;
    end
    prev_req = '0; busy_cnt = 0; cyc = 0; finished = 1'b0; fault_seen = 1'b0;
    bist_en = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      req = ch_req;
      fault_pulse = 1'b0;
      if (cyc == 1) begin
        check({name, ":start_rult"}, 32'(ch_rult), 32'hF);
        check({name, ":start_fault"}, 32'(fault_rult), 32'd1);
        check({name, ":start_req"}, 32'(req), 32'd1);
      end
      check({name, ":req_onehot"}, 32'($countones(req) <= 1), 32'd1);
      if (done) begin
        finished = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        ack_v = 4'($urandom) & 4'($urandom) & ~req;
        err_v = 4'($urandom);
        for (int c = 0; c < CH; c++) begin
          if (req[c]) begin
            if (!prev_req[c]) begin
              edges[c]++;
              m_cnt[c] = 0;
            end
            m_cnt[c]++;
            if (edges[c] <= 8 && m_cnt[c] == lat_t[c][edges[c]-1]) begin
              ack_v[c] = 1'b1;
              err_v[c] = err_t[c][edges[c]-1];
            end
          end
        end
        prev_req = req;
        ch_ack = ack_v;
        ch_err = err_v;
        if (fault_ch >= 0 && req[fault_ch] && m_cnt[fault_ch] == 1 && !fault_seen) begin
          fault_pulse = 1'b1;
          fault_seen = 1'b1;
        end
        if (abort_ch >= 0 && req[abort_ch] && edges[abort_ch] == 1 && m_cnt[abort_ch] == 1) begin
          for (int c = 0; c < CH; c++) part_rult[c] = (c < abort_ch) ? exp_rult[c] : 1'b1;
          bist_en = 1'b0;
          @(negedge clk);
          ch_ack = '0;
          check({name, ":abort_req"}, 32'(ch_req), 32'd0);
          check({name, ":abort_busy"}, 32'(busy), 32'd0);
          check({name, ":abort_done"}, 32'(done), 32'd0);
          check({name, ":abort_rult"}, 32'(ch_rult), 32'(part_rult));
          @(negedge clk);
          check({name, ":abort_done_hold"}, 32'(done), 32'd0);
          return;
        end
        if (rst_ch >= 0 && req[rst_ch] && edges[rst_ch] == 1 && m_cnt[rst_ch] == 1) begin
          rst_n = 1'b0;
          #1;
          check({name, ":rst_req"}, 32'(ch_req), 32'd0);
          check({name, ":rst_busy"}, 32'(busy), 32'd0);
          check({name, ":rst_done"}, 32'(done), 32'd0);
          check({name, ":rst_rult"}, 32'(ch_rult), 32'hF);
          check({name, ":rst_fault"}, 32'(fault_rult), 32'd1);
          ch_ack = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
    check({name, ":reached_done"}, 32'(finished), 32'd1);
    check({name, ":rult"}, 32'(ch_rult), 32'(exp_rult));
    check({name, ":fault"}, 32'(fault_rult), (fault_ch >= 0) ? 32'd0 : 32'd1);
    check({name, ":busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({name, ":req_idle"}, 32'(ch_req), 32'd0);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s:req_count_ch%0d", name, c), 32'(edges[c]), 32'(exp_edges[c]));
    end
    bist_en = 1'b0;
    ch_ack = '0;
    @(negedge clk);
    check({name, ":end_done"}, 32'(done), 32'd0);
    check({name, ":end_busy"}, 32'(busy), 32'd0);
    check({name, ":end_rult_held"}, 32'(ch_rult), 32'(exp_rult));
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req", 32'(ch_req), 32'd0);
    check("reset_rult", 32'(ch_rult), 32'hF);
    check("reset_fault", 32'(fault_rult), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    run_test("all_clean", -1, -1, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    err_t[2][0] = 1'b1;
    err_t[2][2] = 1'b1;
    run_test("ch2_err", -1, -1, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 3, 1'b0);
    set_fixed(1, 1000);
    run_test("ch1_silent", -1, -1, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    run_test("fault_ch3", -1, 3, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    set_fixed(0, TMO);
    run_test("ack_at_timeout", -1, -1, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    run_test("abort_ch1", 1, -1, -1);

    for (int c = 0; c < CH; c++) set_clean(c, 2, 1'b0);
    run_test("reset_mid", -1, -1, 2);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < CH; c++) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0) set_fixed(c, 1000);
        else if (kind == 1) set_fixed(c, TMO);
        else set_clean(c, 3, 1'b1);
      end
      run_test($sformatf("random%0d", r), -1, ($urandom_range(0, 3) == 0) ? 2 : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
